fifo_wr_arbiter: RTL

Write-side arbiter for the asynchronous FIFO. It shares the single FIFO write port (winc/wdata, throttled by wfull) between NREQ requesters in the write clock domain. Grants are round-robin, each grant is a bounded burst, and a full FIFO stalls the burst without losing it. The block is purely write-domain and sits directly in front of the FIFO write-pointer/full logic.

---
 rtl/fifo_wr_arbiter.sv | 106 ++++++++++
 1 files changed

// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fifo_wr_arbiter: round-robin burst arbiter for the async FIFO write port  |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module fifo_wr_arbiter #(
  parameter int DSIZE    = 8,
  parameter int NREQ     = 4,
  parameter int MAXBURST = 4
) (
  input  logic                      wclk,
  input  logic                      wrst_n,
  input  logic [NREQ-1:0]           req,
  input  logic [NREQ*DSIZE-1:0]     req_data,
  input  logic                      wfull,
  output logic                      winc,
  output logic [DSIZE-1:0]          wdata,
  output logic [NREQ-1:0]           ack,
  output logic                      busy,
  output logic [$clog2(NREQ)-1:0]   owner
);

  localparam int PW = $clog2(NREQ);
  localparam int BW = $clog2(MAXBURST) + 1;

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_GRANT = 1'b1;

  localparam logic [BW-1:0] LAST_BEAT = BW'(MAXBURST - 1);
  localparam logic [PW-1:0] LAST_REQ  = PW'(NREQ - 1);
  localparam logic [PW:0]   NREQ_W    = (PW+1)'(NREQ);
  localparam logic [NREQ-1:0] ONE_HOT0 = {{(NREQ-1){1'b0}}, 1'b1};

  logic [0:0]      state;
  logic [0:0]      state_nxt;
  logic [BW-1:0]   beat_cnt;
  logic [PW-1:0]   rr_ptr;
  logic [PW-1:0]   pick_idx;
  logic            pick_valid;
  logic            end_grant;
  logic [PW:0]     scan;
  logic [DSIZE-1:0] data_arr [NREQ];

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign data_arr[gi] = req_data[gi*DSIZE +: DSIZE];
    end
  endgenerate

  // Scan downward so the requester closest to rr_ptr is the last one kept.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    scan       = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      scan = {1'b0, rr_ptr} + (PW+1)'(k);
      if (scan >= NREQ_W) scan = scan - NREQ_W;
      if (req[scan[PW-1:0]]) begin
        pick_valid = 1'b1;
        pick_idx   = scan[PW-1:0];
      end
    end
  end

  always_ff @(posedge wclk) begin
    if (!wrst_n) begin
      state    <= S_IDLE;
      owner    <= '0;
      beat_cnt <= '0;
      rr_ptr   <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_IDLE && pick_valid) begin
        owner    <= pick_idx;
        beat_cnt <= '0;
      end
      if (winc) beat_cnt <= beat_cnt + BW'(1);
      if (end_grant) rr_ptr <= (owner == LAST_REQ) ? '0 : owner + PW'(1);
    end
  end

  always_comb begin
    state_nxt = state;
    end_grant = 1'b0;
    case (state)
      S_IDLE: begin
        if (pick_valid) state_nxt = S_GRANT;
      end
      S_GRANT: begin
        // A last beat coinciding with a request drop is a single end event.
        end_grant = !req[owner] || (winc && beat_cnt == LAST_BEAT);
        if (end_grant) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy  = (state == S_GRANT);
    winc  = wrst_n & busy & req[owner] & ~wfull;
    ack   = winc ? (ONE_HOT0 << owner) : '0;
    wdata = busy ? data_arr[owner] : '0;
  end

endmodule
`default_nettype wire
